// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch FSM state encoding and small address helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int          INST_W       = 32;
  localparam int          ADDR_W       = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// 32-bit enable counter counting performed fetches, wraps modulo 2^32.
// Latency: count visible the cycle after the enabled edge.
// Backpressure: none; counts whenever en_i is high.
module fetch_perf_cnt
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Next count: increment on enable, natural wrap at the top.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 32'd1;
  end

  // Counter register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns PC, reads comb. instruction memory into IR, accepts redirects.
// Latency: fetch_req at edge N -> ir/ir_valid updated after edge N; redirect visible next cycle.
// Backpressure: IR held under ir_valid until ir_ack; req+ack together give 1 fetch/cycle.
// Optional INST_FETCH_PERF_EN adds the fetch_cnt retired-fetch counter port.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              ir_ack,
  input  logic              pc_we,
  input  logic [ADDR_W-1:0] pc_wdata,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [INST_W-1:0] im_inst,
  output logic [INST_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_link,
  output logic              addr_fault
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [ADDR_W-1:0] fetch_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic              fault_q, fault_d;

  logic              do_fetch;
  logic              redir_ok;
  logic              redir_bad;

  // Output/decode logic: a fetch happens only when the IR is free (or being
  // freed by ack this cycle) and no redirect competes for the PC.
  always_comb begin
    ir_valid  = (state_q == FETCH_HOLD);
    redir_ok  = pc_we &&  is_word_aligned(pc_wdata);
    redir_bad = pc_we && !is_word_aligned(pc_wdata);
    do_fetch  = fetch_req && !pc_we && ((state_q == FETCH_IDLE) || ir_ack);
  end

  // Next-state logic: ack empties the IR unless a refill happens in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE: if (do_fetch) state_d = FETCH_HOLD;
      FETCH_HOLD: if (ir_ack)   state_d = do_fetch ? FETCH_HOLD : FETCH_IDLE;
      default:                  state_d = FETCH_IDLE;
    endcase
  end

  // Datapath next values: redirect beats increment; misaligned redirect only flags.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    link_d  = link_q;
    fault_d = fault_q | redir_bad;
    if (redir_ok) begin
      pc_d = pc_wdata;
    end else if (do_fetch) begin
      pc_d = pc_q + PC_STEP;
    end
    if (do_fetch) begin
      ir_d   = im_inst;
      link_d = pc_q + PC_STEP;
    end
  end

  // State register: async clear also aborts a fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      link_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      link_q  <= link_d;
      fault_q <= fault_d;
    end
  end

  assign im_addr    = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign pc_link    = link_q;
  assign addr_fault = fault_q;

`ifdef INST_FETCH_PERF_EN
  fetch_perf_cnt u_perf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (do_fetch),
    .cnt_o (fetch_cnt)
  );
`else
  // No performance counter in this build.
`endif

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the multi-cycle CPU. It owns the program counter, drives the word address into the combinational instruction memory, and latches the returned word into the instruction register. It holds that word for the control unit under a valid/ack handshake and accepts PC redirects for branches and jumps.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control unit requests a fetch at the current PC.
- ir_ack  in  1  control unit has consumed the IR contents.
- pc_we  in  1  load PC from pc_wdata (branch/jump redirect).
- pc_wdata  in  32  redirect target.
- im_addr  out  32  byte address to instruction memory (memory indexes [11:2]).
- im_inst  in  32  instruction word returned combinationally for im_addr.
- ir  out  32  instruction register.
- ir_valid  out  1  ir holds an unconsumed instruction.
- pc  out  32  current PC register.
- pc_link  out  32  address of the instruction in ir, plus 4 (link value).
- addr_fault  out  1  sticky: a misaligned redirect was rejected.
- fetch_cnt  out  32  retired-fetch counter (only with INST_FETCH_PERF_EN).

## Operation
- States: IDLE (ir empty), HOLD (ir_valid=1).
- im_addr = pc at all times, combinationally.
- Fetch in IDLE: fetch_req=1 and pc_we=0 gives:
  - ir <= im_inst; pc_link <= pc+4; pc <= pc+4; ir_valid <= 1; go to HOLD.
- HOLD actions:
  - fetch_req is ignored unless ir_ack=1 in the same cycle.
  - ir_ack=1 and fetch_req=1 and pc_we=0: back-to-back fetch, same updates as above, stay in HOLD.
  - ir_ack=1 in any other case: ir_valid <= 0; go to IDLE. ir and pc_link keep their old values.
- Redirect: pc_we=1 with pc_wdata[1:0]==2'b00 gives pc <= pc_wdata in any state.
  - pc_we has priority over the increment. A fetch_req in the same cycle is dropped, and the control unit must reassert it.
  - ir, pc_link and ir_valid are unaffected by a redirect, except that ir_ack in the same cycle still returns HOLD to IDLE.
- Misaligned redirect: pc_wdata[1:0]!=0 leaves pc unchanged and sets addr_fault=1. addr_fault clears only on reset.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no range check. Addresses at or above 4 KB alias in memory.

## Timing
- Reset values: pc=RESET_PC, im_addr=RESET_PC, ir=0, ir_valid=0, pc_link=0, addr_fault=0, fetch_cnt=0, state=IDLE.
- Reset assertion clears all state immediately, including mid-fetch. The first fetch_req is honored on the first rising edge after rst_n deasserts.
- Fetch latency: fetch_req sampled at edge N means ir and ir_valid are updated after edge N. im_inst must be stable for pc before edge N.
- Throughput: up to one instruction per cycle when ack and req are held high together in HOLD.
- The redirect is visible on pc/im_addr the cycle after the pc_we edge.

## Configuration
- INST_FETCH_PERF_EN defined:
  - Adds the fetch_cnt port.
  - The counter increments by 1 on every performed fetch, including back-to-back fetches, and wraps at 2^32.
- INST_FETCH_PERF_EN undefined:
  - fetch_cnt port and counter logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - INST_W=32, ADDR_W=32, PC_STEP=4.
  - Default RESET_PC constant.
  - The fetch state enum (FETCH_IDLE, FETCH_HOLD).
- Sub-module fetch_perf_cnt is a 32-bit enable counter with async active-low reset. It is instantiated only under INST_FETCH_PERF_EN.
- Everything else is flat in inst_fetch.

## Test plan
- Reset, then memory words 0x20080001 at 0x0 and 0x20090002 at 0x4. Pulse fetch_req, ack, fetch_req -> ir=0x20080001 then 0x20090002; pc=0x8; pc_link=0x8.
- Back-to-back: hold fetch_req=ir_ack=1 for 4 cycles from pc=0 -> 4 consecutive words in ir; ir_valid stays 1; pc=0x10; fetch_cnt=4 (perf build).
- Redirect and fetch in the same cycle: pc_we=1, pc_wdata=0x40, fetch_req=1 -> pc=0x40, ir unchanged, ir_valid unchanged. Next fetch_req loads the word at 0x40.
- Misaligned redirect: pc_wdata=0x42 -> pc unchanged, addr_fault=1 and stays 1 after a later aligned redirect to 0x80.
- Wrap: redirect to 0xFFFFFFFC, then fetch -> pc=0x0, pc_link=0x0, im_addr=0x0.
- Async reset asserted between edges while in HOLD -> ir_valid=0, pc=RESET_PC immediately, without waiting for clk.
